// File: rtl/led_irq_ctrl.sv
// ---------------------------------------------------------------------------
// led_irq_ctrl
//
// Register-mapped control and interrupt front end for the LED blink counter.
//
// It drives the blink counter's divider value and reload strobe from a
// single-cycle register bus. It edge-detects the counter's stretched
// interrupt pulse and latches a pending flag with overrun detection. It
// counts interrupt events. It presents a masked, registered level
// interrupt to the GIC. That interrupt stays high until software clears
// PEND or clears IE.
//
// Ports
//   clk100      in   1      system clock, 100 MHz
//   rst         in   1      synchronous, active-high reset
//   irq_i       in   1      stretched interrupt pulse from the blink counter
//   div_o       out  DIV_W  divider value to the blink counter
//   wren_o      out  1      one-cycle reload strobe to the blink counter
//   reg_wr      in   1      register write strobe
//   reg_rd      in   1      register read strobe
//   reg_addr    in   4      byte address, word aligned ([1:0] ignored)
//   reg_wdata   in   32     write data
//   reg_rdata   out  32     read data (holds until the next read)
//   reg_rvalid  out  1      read data valid, one-cycle pulse per read
//   irq_o       out  1      level interrupt to the GIC
//
// Register map (reg_addr[3:2])
//   0x0 CTRL  bit0 IE, read/write
//   0x4 DIV   bits[DIV_W-1:0], read/write; every write pulses wren_o
//   0x8 STAT  bit0 PEND, bit1 OVR, write-one-to-clear
//   0xC CNT   event count, read-only; any write clears it
//   Unmapped bits read as 0.
// ---------------------------------------------------------------------------
module led_irq_ctrl #(
  parameter int DIV_W = 12,
  parameter int CNT_W = 32
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             irq_i,
  output logic [DIV_W-1:0] div_o,
  output logic             wren_o,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [3:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             reg_rvalid,
  output logic             irq_o
);

  // -------------------------------------------------------------------------
  // Register bus semantics
  //
  // The bus has no ready signal and never stalls. Every reg_wr or reg_rd
  // strobe is accepted in the cycle it is sampled high.
  //
  // Write: the new value is visible in the cycle after the strobe.
  //
  // Read: reg_rvalid pulses for exactly one cycle, in the cycle after the
  // strobe. reg_rdata carries the register value from before any write in
  // the same cycle. reg_rdata keeps that value until the next read.
  //
  // Simultaneous read and write: reg_rd and reg_wr may be asserted in the
  // same cycle. Both take effect, and the read returns the old value.
  // -------------------------------------------------------------------------

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_DIV  = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_CNT  = 2'd3;

  // State registers
  logic             ie_q;
  logic             pend_q;
  logic             ovr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic             irq_q;

  // Address bits [1:0] and write-data bits above the widest field carry
  // no information. They are gathered here so their lack of use is explicit.
  logic unused_ok;
  assign unused_ok = &{1'b0, reg_addr[1:0], reg_wdata[31:DIV_W]};

  // -------------------------------------------------------------------------
  // Write decode
  // -------------------------------------------------------------------------
  logic [1:0] word_sel;
  logic       wr_ctrl;
  logic       wr_div;
  logic       wr_stat;
  logic       wr_cnt;
  logic       clr_pend;
  logic       clr_ovr;

  assign word_sel = reg_addr[3:2];
  assign wr_ctrl  = reg_wr && (word_sel == ADDR_CTRL);
  assign wr_div   = reg_wr && (word_sel == ADDR_DIV);
  assign wr_stat  = reg_wr && (word_sel == ADDR_STAT);
  assign wr_cnt   = reg_wr && (word_sel == ADDR_CNT);
  assign clr_pend = wr_stat && reg_wdata[0];
  assign clr_ovr  = wr_stat && reg_wdata[1];

  // -------------------------------------------------------------------------
  // Rising-edge detect on the stretched pulse
  //
  // irq_q resets to 0. If irq_i is already high when reset is released,
  // that counts as one fresh event. A pulse held high for many cycles
  // produces a single edge.
  // -------------------------------------------------------------------------
  logic irq_edge;
  assign irq_edge = irq_i & ~irq_q;

  // -------------------------------------------------------------------------
  // Next-state logic for the status and counter registers
  // -------------------------------------------------------------------------
  logic             pend_d;
  logic             ovr_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    cnt_d  = cnt_q;

    // PEND: a new edge outranks a same-cycle clear. Otherwise the
    // interrupt raised in that cycle would be lost.
    if (irq_edge) begin
      pend_d = 1'b1;
    end else if (clr_pend) begin
      pend_d = 1'b0;
    end

    // OVR: an overrun compares against PEND from before any same-cycle
    // write. If an edge overruns, OVR is set, even when software clears
    // OVR in that cycle.
    if (irq_edge && pend_q) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end

    // CNT: a write clears the count. An edge in the same cycle is
    // counted on top of the cleared value, so the result is 1.
    // Increments wrap from all-ones to 0.
    if (wr_cnt && irq_edge) begin
      cnt_d = CNT_W'(1);
    end else if (wr_cnt) begin
      cnt_d = '0;
    end else if (irq_edge) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Read mux: register values from before any same-cycle write
  // -------------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = 32'd0;
    unique case (word_sel)
      ADDR_CTRL: rd_mux = {31'd0, ie_q};
      ADDR_DIV:  rd_mux = 32'(div_q);
      ADDR_STAT: rd_mux = {30'd0, ovr_q, pend_q};
      ADDR_CNT:  rd_mux = 32'(cnt_q);
      default:   rd_mux = 32'd0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers and the reload strobe to the blink counter
  //
  // wren_o accompanies every DIV write, even one that rewrites the current
  // value. Software uses that write to restart the blink counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk100) begin
    if (rst) begin
      ie_q   <= 1'b0;
      div_q  <= '0;
      wren_o <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ie_q <= reg_wdata[0];
      end
      if (wr_div) begin
        div_q <= reg_wdata[DIV_W-1:0];
      end
      wren_o <= wr_div;
    end
  end

  assign div_o = div_q;

  // -------------------------------------------------------------------------
  // Interrupt status, event counter and registered GIC interrupt
  //
  // irq_o is registered from the current PEND and IE. Software therefore
  // sees irq_o respond two cycles after the event or register write that
  // caused the change.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk100) begin
    if (rst) begin
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
      cnt_q  <= '0;
      irq_o  <= 1'b0;
    end else begin
      irq_q  <= irq_i;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      cnt_q  <= cnt_d;
      irq_o  <= pend_q & ie_q;
    end
  end

  // -------------------------------------------------------------------------
  // Read response
  // -------------------------------------------------------------------------
  always_ff @(posedge clk100) begin
    if (rst) begin
      reg_rdata  <= 32'd0;
      reg_rvalid <= 1'b0;
    end else begin
      reg_rvalid <= reg_rd;
      if (reg_rd) begin
        reg_rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_led_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_irq_ctrl
//
// Directed test of led_irq_ctrl with hand-computed expected values.
//
// The counter is built 8 bits wide so that its wrap-around point can be
// reached by real pulses in a short run.
//
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_led_irq_ctrl;

  localparam int DIV_W = 12;
  localparam int CNT_W = 8;

  localparam logic [3:0] A_CTRL = 4'h0;
  localparam logic [3:0] A_DIV  = 4'h4;
  localparam logic [3:0] A_STAT = 4'h8;
  localparam logic [3:0] A_CNT  = 4'hC;

  // -------------------------------------------------------------------------
  // Clock and DUT
  // -------------------------------------------------------------------------
  logic             clk100 = 1'b0;
  logic             rst;
  logic             irq_i;
  logic [DIV_W-1:0] div_o;
  logic             wren_o;
  logic             reg_wr;
  logic             reg_rd;
  logic [3:0]       reg_addr;
  logic [31:0]      reg_wdata;
  logic [31:0]      reg_rdata;
  logic             reg_rvalid;
  logic             irq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk100 = ~clk100;

  led_irq_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk100     (clk100),
    .rst        (rst),
    .irq_i      (irq_i),
    .div_o      (div_o),
    .wren_o     (wren_o),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .irq_o      (irq_o)
  );

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    reg_wr    = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    tick();
    reg_wr    = 1'b0;
  endtask

  // Read, check data and the single-cycle valid pulse
  task automatic bus_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    reg_rd   = 1'b1;
    reg_addr = addr;
    tick();
    reg_rd   = 1'b0;
    chk({tag, "_rvalid"}, 32'(reg_rvalid), 32'd1);
    chk(tag, reg_rdata, exp);
    tick();
    chk({tag, "_rvalid_low"}, 32'(reg_rvalid), 32'd0);
  endtask

  task automatic pulse();
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    irq_i     = 1'b0;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    reg_addr  = 4'h0;
    reg_wdata = 32'd0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_div",    32'(div_o),      32'd0);
    chk("rst_wren",   32'(wren_o),     32'd0);
    chk("rst_irq",    32'(irq_o),      32'd0);
    chk("rst_rvalid", 32'(reg_rvalid), 32'd0);
    chk("rst_rdata",  reg_rdata,       32'd0);
    bus_read("rst_ctrl", A_CTRL, 32'd0);
    bus_read("rst_dreg", A_DIV,  32'd0);
    bus_read("rst_stat", A_STAT, 32'd0);
    bus_read("rst_cnt",  A_CNT,  32'd0);

    // DIV write and strobe
    bus_write(A_DIV, 32'h0000_002B);
    chk("div_val",   32'(div_o),  32'h2B);
    chk("div_wren1", 32'(wren_o), 32'd1);
    tick();
    chk("div_wren0", 32'(wren_o), 32'd0);
    bus_read("div_read", A_DIV, 32'h0000_002B);

    // Upper write-data bits are dropped. Back-to-back writes give
    // back-to-back strobes, even when the value does not change.
    bus_write(A_DIV, 32'hFFFF_F123);
    chk("div_b2b_a", 32'(wren_o), 32'd1);
    bus_write(A_DIV, 32'hFFFF_F123);
    chk("div_b2b_b", 32'(wren_o), 32'd1);
    chk("div_trunc", 32'(div_o),  32'h123);
    tick();
    chk("div_b2b_end", 32'(wren_o), 32'd0);

    // Interrupt path with IE=1 and irq_i held for 11 cycles
    bus_write(A_CTRL, 32'd1);
    irq_i = 1'b1;
    tick();                          // edge sampled here
    chk("irq_n1", 32'(irq_o), 32'd0);
    tick();
    chk("irq_n2", 32'(irq_o), 32'd1);
    repeat (9) tick();
    irq_i = 1'b0;
    bus_read("one_evt_cnt",  A_CNT,  32'd1);
    bus_read("one_evt_stat", A_STAT, 32'd1);

    // W1C of PEND
    bus_write(A_STAT, 32'd1);
    chk("clr_m1", 32'(irq_o), 32'd1);
    tick();
    chk("clr_m2", 32'(irq_o), 32'd0);

    // IE masks irq_o without clearing PEND
    pulse();                         // CNT=2, PEND=1
    tick();
    chk("mask_pre", 32'(irq_o), 32'd1);
    bus_write(A_CTRL, 32'd0);
    chk("mask_m1", 32'(irq_o), 32'd1);
    tick();
    chk("mask_m2", 32'(irq_o), 32'd0);
    bus_read("mask_stat", A_STAT, 32'd1);

    // Simultaneous read and write: the read returns the old value
    bus_write(A_CTRL, 32'd1);
    reg_rd    = 1'b1;
    reg_wr    = 1'b1;
    reg_addr  = A_CTRL;
    reg_wdata = 32'd0;
    tick();
    reg_rd = 1'b0;
    reg_wr = 1'b0;
    chk("rdwr_old", reg_rdata, 32'd1);
    tick();
    bus_read("rdwr_new", A_CTRL, 32'd0);

    // Three pulses without clearing
    bus_write(A_STAT, 32'd3);
    bus_write(A_CNT, 32'hDEAD_BEEF);
    bus_read("cnt_clr", A_CNT, 32'd0);
    repeat (3) pulse();
    bus_read("three_cnt",  A_CNT,  32'd3);
    bus_read("three_stat", A_STAT, 32'd3);
    bus_write(A_STAT, 32'd2);
    bus_read("ovr_clr", A_STAT, 32'd1);

    // Edge together with a W1C of PEND, while PEND is already set
    irq_i     = 1'b1;
    reg_wr    = 1'b1;
    reg_addr  = A_STAT;
    reg_wdata = 32'd1;
    tick();
    reg_wr = 1'b0;
    irq_i  = 1'b0;
    tick();
    bus_read("edge_w1c_stat", A_STAT, 32'd3);

    // Edge together with a CNT write
    irq_i     = 1'b1;
    reg_wr    = 1'b1;
    reg_addr  = A_CNT;
    reg_wdata = 32'd0;
    tick();
    reg_wr = 1'b0;
    irq_i  = 1'b0;
    tick();
    bus_read("edge_cntwr", A_CNT, 32'd1);

    // Edge with a W1C of OVR and PEND already set: the overrun wins
    irq_i     = 1'b1;
    reg_wr    = 1'b1;
    reg_addr  = A_STAT;
    reg_wdata = 32'd2;
    tick();
    reg_wr = 1'b0;
    irq_i  = 1'b0;
    tick();
    bus_read("edge_w1c_ovr_set", A_STAT, 32'd3);

    // Edge with a W1C of OVR and PEND clear: OVR is cleared
    bus_write(A_STAT, 32'd1);        // PEND=0, OVR stays 1
    irq_i     = 1'b1;
    reg_wr    = 1'b1;
    reg_addr  = A_STAT;
    reg_wdata = 32'd2;
    tick();
    reg_wr = 1'b0;
    irq_i  = 1'b0;
    tick();
    bus_read("edge_w1c_ovr_clr", A_STAT, 32'd1);

    // Counter wrap at 2^CNT_W - 1
    bus_write(A_CNT, 32'd0);
    repeat ((1 << CNT_W) - 1) pulse();
    bus_read("cnt_max", A_CNT, 32'h0000_00FF);
    pulse();
    bus_read("cnt_wrap", A_CNT, 32'd0);

    // Reset mid-operation, with irq_i high and a DIV write in flight
    bus_write(A_CTRL, 32'd1);
    irq_i = 1'b1;
    tick();
    tick();
    chk("pre_rst_irq", 32'(irq_o), 32'd1);
    rst       = 1'b1;
    reg_wr    = 1'b1;
    reg_addr  = A_DIV;
    reg_wdata = 32'h0000_0555;
    tick();
    reg_wr = 1'b0;
    chk("rst_mid_div",    32'(div_o),      32'd0);
    chk("rst_mid_wren",   32'(wren_o),     32'd0);
    chk("rst_mid_irq",    32'(irq_o),      32'd0);
    chk("rst_mid_rdata",  reg_rdata,       32'd0);
    chk("rst_mid_rvalid", 32'(reg_rvalid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    bus_read("post_rst_cnt",  A_CNT,  32'd1);
    bus_read("post_rst_stat", A_STAT, 32'd1);
    bus_read("post_rst_ctrl", A_CTRL, 32'd0);
    chk("post_rst_irq", 32'(irq_o), 32'd0);
    irq_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop in case the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/led_irq_ctrl.md
# led_irq_ctrl

Register-mapped control and interrupt front end for the LED blink counter. It drives the counter's divider and write-strobe inputs from a simple single-cycle register bus. It edge-detects the counter's stretched interrupt pulse, latches a pending status with overrun detection and counts events. It presents a masked, level interrupt to the GIC that stays high until software clears it.

## Interface

- DIV_W, 12: width of divider register and div_o
- CNT_W, 32: width of event counter (must be ≤ 32)

- clk100  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- irq_i  in  1  stretched interrupt pulse from blink counter, clk100 domain, ≥1 cycle wide
- div_o  out  DIV_W  divider value to blink counter
- wren_o  out  1  one-cycle strobe: blink counter reloads/toggles
- reg_wr  in  1  register write strobe
- reg_rd  in  1  register read strobe
- reg_addr  in  4  byte address, word aligned; bits [1:0] ignored
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data
- reg_rvalid  out  1  read data valid, one-cycle pulse
- irq_o  out  1  level interrupt to GIC

## Operation

- Register map (addr[3:2]):
  - 0x0 CTRL: bit0 IE (irq enable), R/W; other bits read 0.
  - 0x4 DIV: bits[DIV_W-1:0], R/W. Every write pulses wren_o, including a write of an unchanged value.
  - 0x8 STAT: bit0 PEND, bit1 OVR; both W1C, other bits read 0.
  - 0xC CNT: event count, read-only value; any write clears it to 0 regardless of data.
- Edge detect: irq_q <= irq_i; edge = irq_i & ~irq_q. irq_q resets to 0, so irq_i high at reset release produces one edge.
- Edge handling:
  - PEND <= 1.
  - If PEND is already 1 on an edge, OVR <= 1.
  - CNT <= CNT+1, wrapping from all-ones to 0.
- Simultaneous events in the same cycle:
  - Edge + W1C of PEND: PEND stays 1. OVR is evaluated against the pre-write PEND.
  - Edge + W1C of OVR: OVR is set only if this edge overruns; otherwise cleared.
  - Edge + CNT write: CNT becomes 1.
- Reads:
  - Read data is the register value before any same-cycle write.
  - reg_rd and reg_wr together: both are performed.
  - Unmapped bits read 0.
- irq_o <= PEND & IE, registered. Clearing IE masks irq_o but does not clear PEND.
- Reset values: div_o=0, wren_o=0, IE=0, PEND=0, OVR=0, CNT=0, reg_rdata=0, reg_rvalid=0, irq_o=0, irq_q=0.
- div_o=0 is legal; it selects the blink counter's exact 1 s period.

## Timing

- DIV write at cycle N: div_o takes the new value and wren_o=1 at N+1; wren_o=0 at N+2. Back-to-back writes give back-to-back strobes.
- Read at cycle N: reg_rdata valid and reg_rvalid=1 at N+1. reg_rdata holds until the next read; reg_rvalid is high for exactly 1 cycle per read.
- Interrupt path, irq_i rising at cycle N (sampled):
  - edge at N;
  - PEND=1 and CNT incremented at N+1;
  - irq_o=1 at N+2 if IE=1.
- irq_i held high for many cycles gives exactly one event.
- W1C of PEND at cycle M: PEND=0 at M+1, irq_o=0 at M+2.
- IE write at cycle M with PEND=1: irq_o follows at M+2.
- rst asserted mid-operation overrides everything on the next edge; all state returns to reset values, including a wren_o in flight.

## Test plan

- Reset, then read all four registers -> rdata 0 each, rvalid one cycle after each rd; div_o=0, irq_o=0.
- Write DIV=0x02B -> div_o=0x02B and wren_o high for exactly 1 cycle, one cycle after reg_wr. Read DIV -> 0x0000002B.
- IE=1, irq_i high 11 cycles -> PEND=1, CNT=1, irq_o=1 two cycles after the rise. Write STAT=0x1 -> irq_o=0 two cycles later.
- Three irq_i pulses without clearing -> CNT=3, STAT=0x3. W1C 0x2 -> STAT=0x1.
- Edge in the same cycle as STAT write 0x1 and CNT write -> PEND remains 1, OVR=1 (PEND was set), CNT=1.
- Preload 2^CNT_W-1 events (force or long run), one more pulse -> CNT wraps to 0. Assert rst while irq_i is high -> all outputs 0. On release, one new event: CNT=1.
